vdp_interrupt: RTL and testbench
================================

Name: vdp_interrupt

Overview:
- Interrupt generator directly downstream of vdp_ssg.
- Consumes the per-line horizontal strobe, the vertical-blanking-start strobe and the current display line from vdp_ssg, together with the interrupt-control register bits.
- Maintains the VSYNC flag (S#0 bit7, "F") and the line-match flag (S#1 bit0, "FH").
- Drives the registered, active-low CPU interrupt request pvdp_int_n; flags are cleared by status-read strobes from the register interface.

Parameters:
- LINE_W, 9, width of predotcounter_y input.
- CMP_W, 8, number of low line bits compared against reg_r19_hsync_int_line.

Ports:
- clk21m  in  1  system clock, 21.48 MHz.
- reset  in  1  asynchronous, active-high reset.
- enahsync  in  1  one-cycle strobe from vdp_ssg, once per line at the horizontal interrupt point.
- v_blanking_start  in  1  one-cycle strobe from vdp_ssg at the first vertical-blanking line.
- predotcounter_y  in  LINE_W  current display line from vdp_ssg.
- reg_r19_hsync_int_line  in  CMP_W  line-interrupt compare value (R#19).
- reg_r0_hsync_int_en  in  1  IE1, line interrupt enable.
- reg_r1_vsync_int_en  in  1  IE0, vertical interrupt enable.
- clr_vsync_int  in  1  one-cycle strobe: S#0 read by CPU.
- clr_hsync_int  in  1  one-cycle strobe: S#1 read by CPU.
- vsync_int_flag  out  1  F flag, S#0 bit7.
- hsync_int_flag  out  1  FH flag, S#1 bit0.
- line_match  out  1  registered compare result, valid from the cycle after enahsync.
- pvdp_int_n  out  1  interrupt request to CPU, active low.

Behaviour:
- Reset (async, active-high): vsync_int_flag=0, hsync_int_flag=0, line_match=0, pvdp_int_n=1, all internal pipeline registers=0.
- Stage 1 (line compare), on the cycle enahsync=1:
  - match_d <= (predotcounter_y[LINE_W-1]==0) && (predotcounter_y[CMP_W-1:0]==reg_r19_hsync_int_line).
  - Register that match_d is written into: hs_pend <= 1 if match_d, else 0.
  - line_match <= match_d.
  - Lines 256..511 never match. With enahsync=0, line_match holds and hs_pend <= 0.
- Stage 2 (flags), one cycle after the stage-1 capture:
  - hs_pend=1 sets hsync_int_flag. FH therefore rises exactly 2 clocks after the enahsync strobe.
  - v_blanking_start=1 sets vsync_int_flag on the next clock edge (1-clock latency).
  - clr_hsync_int=1 clears hsync_int_flag; clr_vsync_int=1 clears vsync_int_flag.
  - Set and clear in the same cycle: set wins and the flag stays 1, so no event is lost.
  - Flags are set regardless of IE bits; IE only gates the request.
- Stage 3 (request): pvdp_int_n <= ~((vsync_int_flag & reg_r1_vsync_int_en) | (hsync_int_flag & reg_r0_hsync_int_en)). This is a level request, one clock after the flag/IE change.
- Enabling IE while the flag is already 1 asserts pvdp_int_n=0 one clock later. Disabling IE deasserts pvdp_int_n one clock later without touching the flag.
- reg_r19 or predotcounter_y changing between strobes has no effect; they are sampled only on the enahsync cycle.
- enahsync and v_blanking_start in the same cycle: both are processed independently.
- Repeated clear strobes with the flag already 0: no effect.
- Reset mid-operation clears all flags and pending state immediately; pvdp_int_n=1 asynchronously.

Optional Feature:
- Macro: VDP_INTERRUPT_FRAME_COUNTER_EN.
- Defined:
  - Adds output frame_cnt (16 bits) and input clr_frame_cnt (1 bit).
  - frame_cnt resets to 0 and increments (wraps 0xFFFF->0x0000) on each v_blanking_start.
  - clr_frame_cnt=1 forces 0; if it coincides with v_blanking_start, the counter becomes 0.
  - Used for frame-accurate debug and in simulation.
- Not defined: ports and counter absent; all other behaviour identical.

Test Plan:
- Reset release, no strobes for 1000 clocks -> pvdp_int_n=1, both flags 0, line_match=0.
- reg_r19=8'd50, IE1=1, predotcounter_y=9'd50, enahsync pulse at cycle T -> line_match=1 at T+1, hsync_int_flag=1 at T+2, pvdp_int_n=0 at T+3. clr_hsync_int at T+10 -> flag 0 at T+11, pvdp_int_n=1 at T+12.
- predotcounter_y=9'd306 (low byte 50), reg_r19=50, enahsync -> line_match=0, no FH, pvdp_int_n stays 1.
- IE0=0, v_blanking_start pulse -> vsync_int_flag=1, pvdp_int_n=1. Then set IE0=1 -> pvdp_int_n=0 one clock later.
- vsync_int_flag=1, clr_vsync_int and v_blanking_start in the same cycle -> flag remains 1. A clear alone on the next cycle -> flag 0.
- Assert reset while pvdp_int_n=0 with both flags set -> immediate pvdp_int_n=1, flags 0. With VDP_INTERRUPT_FRAME_COUNTER_EN, 3 v_blanking_start pulses -> frame_cnt=3, then reset -> 0.

Source files
------------

// File: rtl/vdp_interrupt.sv
// rtl/vdp_interrupt.sv - VDP line/vsync interrupt generator; optional frame counter via VDP_INTERRUPT_FRAME_COUNTER_EN
// Three-stage pipeline: line compare on enahsync, flag set/clear, registered active-low request.
module vdp_interrupt #(
    parameter int LINE_W = 9,
    parameter int CMP_W  = 8
) (
    input  logic              clk21m,
    input  logic              reset,
    input  logic              enahsync,
    input  logic              v_blanking_start,
    input  logic [LINE_W-1:0] predotcounter_y,
    input  logic [CMP_W-1:0]  reg_r19_hsync_int_line,
    input  logic              reg_r0_hsync_int_en,
    input  logic              reg_r1_vsync_int_en,
    input  logic              clr_vsync_int,
    input  logic              clr_hsync_int,
    output logic              vsync_int_flag,
    output logic              hsync_int_flag,
    output logic              line_match,
    output logic              pvdp_int_n
`ifdef VDP_INTERRUPT_FRAME_COUNTER_EN
    ,
    input  logic              clr_frame_cnt,
    output logic [15:0]       frame_cnt
`endif
);

    logic match_d;
    logic hs_pend_q,    hs_pend_d;
    logic line_match_q, line_match_d;
    logic vsync_flag_q, vsync_flag_d;
    logic hsync_flag_q, hsync_flag_d;
    logic int_n_q,      int_n_d;

    always_comb begin
        // Lines with the MSB set (256 and up) can never match the 8-bit compare value.
        match_d      = (predotcounter_y[LINE_W-1] == 1'b0) &&
                       (predotcounter_y[CMP_W-1:0] == reg_r19_hsync_int_line);
        hs_pend_d    = enahsync & match_d;
        line_match_d = enahsync ? match_d : line_match_q;
        // Set has priority over clear so an event arriving with a status read is kept.
        hsync_flag_d = hs_pend_q | (hsync_flag_q & ~clr_hsync_int);
        vsync_flag_d = v_blanking_start | (vsync_flag_q & ~clr_vsync_int);
        int_n_d      = ~((vsync_flag_q & reg_r1_vsync_int_en) |
                         (hsync_flag_q & reg_r0_hsync_int_en));
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            hs_pend_q    <= 1'b0;
            line_match_q <= 1'b0;
            vsync_flag_q <= 1'b0;
            hsync_flag_q <= 1'b0;
            int_n_q      <= 1'b1;
        end else begin
            hs_pend_q    <= hs_pend_d;
            line_match_q <= line_match_d;
            vsync_flag_q <= vsync_flag_d;
            hsync_flag_q <= hsync_flag_d;
            int_n_q      <= int_n_d;
        end
    end

    assign vsync_int_flag = vsync_flag_q;
    assign hsync_int_flag = hsync_flag_q;
    assign line_match     = line_match_q;
    assign pvdp_int_n     = int_n_q;

`ifdef VDP_INTERRUPT_FRAME_COUNTER_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (clr_frame_cnt) begin
            frame_cnt_d = 16'd0;
        end else if (v_blanking_start) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vdp_interrupt.sv
// tb/tb_vdp_interrupt.sv - scoreboard bench for vdp_interrupt with randomized stimulus
// Expected outputs come from per-cycle input history evaluated with the interrupt rules.
module tb_vdp_interrupt;

    localparam int NH = 16384;

    logic       clk21m = 1'b0;
    logic       reset;
    logic       enahsync;
    logic       v_blanking_start;
    logic [8:0] predotcounter_y;
    logic [7:0] reg_r19_hsync_int_line;
    logic       reg_r0_hsync_int_en;
    logic       reg_r1_vsync_int_en;
    logic       clr_vsync_int;
    logic       clr_hsync_int;
    logic       vsync_int_flag;
    logic       hsync_int_flag;
    logic       line_match;
    logic       pvdp_int_n;
    logic        clr_frame_cnt;
    logic [15:0] frame_cnt_obs;
`ifdef VDP_INTERRUPT_FRAME_COUNTER_EN
    logic [15:0] frame_cnt;
    assign frame_cnt_obs = frame_cnt;
`else
    assign frame_cnt_obs = 16'd0;
`endif

    vdp_interrupt #(.LINE_W(9), .CMP_W(8)) dut (
        .clk21m                 (clk21m),
        .reset                  (reset),
        .enahsync               (enahsync),
        .v_blanking_start       (v_blanking_start),
        .predotcounter_y        (predotcounter_y),
        .reg_r19_hsync_int_line (reg_r19_hsync_int_line),
        .reg_r0_hsync_int_en    (reg_r0_hsync_int_en),
        .reg_r1_vsync_int_en    (reg_r1_vsync_int_en),
        .clr_vsync_int          (clr_vsync_int),
        .clr_hsync_int          (clr_hsync_int),
        .vsync_int_flag         (vsync_int_flag),
        .hsync_int_flag         (hsync_int_flag),
        .line_match             (line_match),
        .pvdp_int_n             (pvdp_int_n)
`ifdef VDP_INTERRUPT_FRAME_COUNTER_EN
        ,
        .clr_frame_cnt          (clr_frame_cnt),
        .frame_cnt              (frame_cnt)
`endif
    );

    always #5 clk21m = ~clk21m;

    typedef struct {
        bit          lm;
        bit          fh;
        bit          fv;
        bit          intn;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int k     = 0;

    bit h_ena[NH], h_vbs[NH], h_ieh[NH], h_iev[NH], h_clrv[NH], h_clrh[NH], h_clrf[NH];
    int h_y[NH], h_r19[NH];
    bit e_lm[NH], e_fh[NH], e_fv[NH];
    logic [15:0] e_fc[NH];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            if (bad <= 30) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    function automatic bit line_hit(input int y, input int r);
        return (y < 256) && (y == r);
    endfunction

    // Record this cycle's inputs, then after the edge derive what the outputs must be.
    task automatic tick();
        exp_t e;
        bit   p_lm, p_fh, p_fv, p_pend;
        logic [15:0] p_fc;
        h_ena[k]  = enahsync;         h_vbs[k]  = v_blanking_start;
        h_ieh[k]  = reg_r0_hsync_int_en; h_iev[k] = reg_r1_vsync_int_en;
        h_clrv[k] = clr_vsync_int;    h_clrh[k] = clr_hsync_int;
        h_clrf[k] = clr_frame_cnt;
        h_y[k]    = int'(predotcounter_y);
        h_r19[k]  = int'(reg_r19_hsync_int_line);
        @(posedge clk21m);
        p_lm   = (k > 0) ? e_lm[k-1] : 1'b0;
        p_fh   = (k > 0) ? e_fh[k-1] : 1'b0;
        p_fv   = (k > 0) ? e_fv[k-1] : 1'b0;
        p_fc   = (k > 0) ? e_fc[k-1] : 16'd0;
        p_pend = (k > 0) ? (h_ena[k-1] && line_hit(h_y[k-1], h_r19[k-1])) : 1'b0;
        e_lm[k] = h_ena[k] ? line_hit(h_y[k], h_r19[k]) : p_lm;
        e_fh[k] = p_pend || (p_fh && !h_clrh[k]);
        e_fv[k] = h_vbs[k] || (p_fv && !h_clrv[k]);
`ifdef VDP_INTERRUPT_FRAME_COUNTER_EN
        e_fc[k] = h_clrf[k] ? 16'd0 : (h_vbs[k] ? p_fc + 16'd1 : p_fc);
`else
        e_fc[k] = 16'd0;
`endif
        e.lm   = e_lm[k];
        e.fh   = e_fh[k];
        e.fv   = e_fv[k];
        e.intn = !((p_fv && h_iev[k]) || (p_fh && h_ieh[k]));
        e.fc   = e_fc[k];
        sb.push_back(e);
        k++;
        #1;
        enahsync         = 1'b0;
        v_blanking_start = 1'b0;
        clr_vsync_int    = 1'b0;
        clr_hsync_int    = 1'b0;
        clr_frame_cnt    = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk21m);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("line_match", int'(line_match), int'(e.lm));
                chk("hsync_int_flag", int'(hsync_int_flag), int'(e.fh));
                chk("vsync_int_flag", int'(vsync_int_flag), int'(e.fv));
                chk("pvdp_int_n", int'(pvdp_int_n), int'(e.intn));
                chk("frame_cnt", int'(frame_cnt_obs), int'(e.fc));
            end
        end
    end

    initial begin : stim
        int yy;
        reset = 1'b1;
        enahsync = 1'b0; v_blanking_start = 1'b0; predotcounter_y = 9'd0;
        reg_r19_hsync_int_line = 8'd0; reg_r0_hsync_int_en = 1'b0; reg_r1_vsync_int_en = 1'b0;
        clr_vsync_int = 1'b0; clr_hsync_int = 1'b0; clr_frame_cnt = 1'b0;
        repeat (3) @(posedge clk21m);
        chk("reset_int_n", int'(pvdp_int_n), 1);
        chk("reset_fh", int'(hsync_int_flag), 0);
        @(negedge clk21m);
        #1 reset = 1'b0;
        k = 0;

        repeat (1000) tick();

        // Line 50 match, then clear by status read.
        reg_r19_hsync_int_line = 8'd50; reg_r0_hsync_int_en = 1'b1; predotcounter_y = 9'd50;
        enahsync = 1'b1; tick();
        repeat (9) tick();
        clr_hsync_int = 1'b1; tick();
        repeat (4) tick();

        // Line 306 shares the low byte but must not match.
        predotcounter_y = 9'd306; enahsync = 1'b1; tick();
        repeat (4) tick();

        // Vsync with IE0 off, then enabled afterwards.
        reg_r1_vsync_int_en = 1'b0; v_blanking_start = 1'b1; tick();
        repeat (3) tick();
        reg_r1_vsync_int_en = 1'b1; repeat (3) tick();

        // Set beats clear; then a lone clear; then repeated clears on a zero flag.
        clr_vsync_int = 1'b1; v_blanking_start = 1'b1; tick();
        clr_vsync_int = 1'b1; tick();
        clr_vsync_int = 1'b1; tick();
        clr_vsync_int = 1'b1; clr_hsync_int = 1'b1; tick();
        reg_r1_vsync_int_en = 1'b0; reg_r0_hsync_int_en = 1'b0; repeat (3) tick();

        // Both flags set with both strobes in one cycle, then asynchronous reset.
        reg_r1_vsync_int_en = 1'b1; reg_r0_hsync_int_en = 1'b1; predotcounter_y = 9'd50;
        enahsync = 1'b1; v_blanking_start = 1'b1; tick();
        repeat (4) tick();
        chk("pre_reset_int_n", int'(pvdp_int_n), 0);
        @(negedge clk21m);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_int_n", int'(pvdp_int_n), 1);
        chk("async_reset_fh", int'(hsync_int_flag), 0);
        chk("async_reset_fv", int'(vsync_int_flag), 0);
        chk("async_reset_lm", int'(line_match), 0);
        @(posedge clk21m);
        @(negedge clk21m);
        #1 reset = 1'b0;
        k = 0;

        // Three frames for the counter, then a reset.
        repeat (3) begin
            v_blanking_start = 1'b1; tick();
            repeat (2) tick();
        end
`ifdef VDP_INTERRUPT_FRAME_COUNTER_EN
        chk("frame_cnt_three", int'(frame_cnt_obs), 3);
        clr_frame_cnt = 1'b1; v_blanking_start = 1'b1; tick();
        tick();
`endif

        for (int i = 0; i < 4000; i++) begin
            enahsync = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) reg_r19_hsync_int_line = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1)
                yy = int'($urandom_range(0, 1)) * 256 + int'(reg_r19_hsync_int_line);
            else
                yy = int'($urandom_range(0, 511));
            predotcounter_y  = 9'(yy);
            v_blanking_start = ($urandom_range(0, 15) == 0);
            clr_vsync_int    = ($urandom_range(0, 5) == 0);
            clr_hsync_int    = ($urandom_range(0, 5) == 0);
            clr_frame_cnt    = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 31) == 0) reg_r0_hsync_int_en = ~reg_r0_hsync_int_en;
            if ($urandom_range(0, 31) == 0) reg_r1_vsync_int_en = ~reg_r1_vsync_int_en;
            tick();
        end

        @(negedge clk21m);
        @(negedge clk21m);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
